// File: rtl/ecg_sample_sequencer.sv
// ecg_sample_sequencer: start/stop ROM address sequencer with read-latency compensation and spike counting.
// Define ECG_SEQ_SPIKE_ADDR_EN to add last_spike_addr, the address of the sample on show at each counted spike.
module ecg_sample_sequencer #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 20,
    parameter int LAST_ADDR = 4095,
    parameter int RD_LAT    = 1,
    parameter int DECIM     = 1,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              KEY,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    input  logic              spike_in,
    output logic              busy,
    output logic              done,
`ifdef ECG_SEQ_SPIKE_ADDR_EN
    output logic [ADDR_W-1:0] last_spike_addr,
`endif
    output logic [CNT_W-1:0]  spike_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
    localparam logic [7:0] DMAX = 8'(DECIM - 1);
    state_t state, nstate;
    logic [7:0] dcnt;
    logic [RD_LAT-1:0] pipe;
    logic [ADDR_W-1:0] naddr;
    logic issued, issue, clr, spike_prev, tap, hit;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign tap  = pipe[RD_LAT-1];
    assign hit  = busy && spike_in && !spike_prev;
    always_comb begin
        nstate = state;
        issue  = 1'b0;
        clr    = 1'b0;
        naddr  = rom_addr;
        case (state)
            IDLE: if (start && !stop) begin
                nstate = RUN;
                issue  = 1'b1;
                clr    = 1'b1;
                naddr  = '0;
            end
            RUN: if (stop) nstate = DRAIN;
                 else if (dcnt == DMAX) begin
                     if (rom_addr == LAST && !loop) nstate = DRAIN;
                     else begin
                         issue = 1'b1;
                         naddr = (rom_addr == LAST) ? '0 : rom_addr + 1'b1;
                     end
                 end
            // issued marks an address presented to the ROM this cycle; pipe tracks it through the ROM latency
            DRAIN: if (!issued && pipe == '0) nstate = DONE;
            default: nstate = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge KEY) begin
        if (KEY) begin
            state        <= IDLE;
            rom_addr     <= '0;
            dcnt         <= '0;
            issued       <= 1'b0;
            pipe         <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            spike_prev   <= 1'b1;
            spike_count  <= '0;
        end else begin
            state        <= nstate;
            rom_addr     <= naddr;
            issued       <= issue;
            pipe         <= RD_LAT'({pipe, issued});
            dcnt         <= (clr || issue) ? '0 : (state == RUN ? dcnt + 1'b1 : dcnt);
            sample_valid <= tap;
            if (tap) sample_out <= rom_data;
            spike_prev   <= spike_in;
            if (clr) spike_count <= '0;
            else if (hit && spike_count != '1) spike_count <= spike_count + 1'b1;
        end
    end
`ifdef ECG_SEQ_SPIKE_ADDR_EN
    logic [ADDR_W-1:0] del_addr, del_next;
    // Delivery is in address order, so a local counter mirrors the address of sample_out
    always_ff @(posedge CLK or posedge KEY) begin
        if (KEY) begin
            del_addr        <= '0;
            del_next        <= '0;
            last_spike_addr <= '0;
        end else if (clr) begin
            del_addr        <= '0;
            del_next        <= '0;
            last_spike_addr <= '0;
        end else begin
            if (tap) begin
                del_addr <= del_next;
                del_next <= (del_next == LAST) ? '0 : del_next + 1'b1;
            end
            if (hit) last_spike_addr <= del_addr;
        end
    end
`endif
endmodule

// File: tb/tb_ecg_sample_sequencer.sv
// tb_ecg_sample_sequencer: directed checks of playback timing, looping, stop, drain and spike counting.
module tb_ecg_sample_sequencer;
    logic clk = 1'b0, key = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0, spike = 1'b0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    logic [11:0] a1, a2, a4, a5;
    logic [19:0] r1, r2, r4, r5, q4, s1, s2, s4, s5;
    logic v1, v2, v4, v5, b1, b2, b4, b5, d1, d2, d4, d5;
    logic [15:0] c1, c2, c4;
    logic [3:0] c5;

    // Sample ROMs: word[n] = n + 100, registered read (two stages for the RD_LAT=2 instance)
    always @(posedge clk) begin
        r1 <= 20'(a1) + 20'd100;
        r2 <= 20'(a2) + 20'd100;
        q4 <= 20'(a4) + 20'd100;
        r4 <= q4;
        r5 <= 20'(a5) + 20'd100;
    end

    ecg_sample_sequencer #(.LAST_ADDR(7)) u1 (.CLK(clk), .KEY(key), .start(start), .stop(stop), .loop(loop),
        .rom_addr(a1), .rom_data(r1), .sample_out(s1), .sample_valid(v1), .spike_in(spike),
        .busy(b1), .done(d1), .spike_count(c1));
    ecg_sample_sequencer #(.LAST_ADDR(3), .DECIM(4)) u2 (.CLK(clk), .KEY(key), .start(start), .stop(stop), .loop(loop),
        .rom_addr(a2), .rom_data(r2), .sample_out(s2), .sample_valid(v2), .spike_in(spike),
        .busy(b2), .done(d2), .spike_count(c2));
    ecg_sample_sequencer #(.LAST_ADDR(7), .RD_LAT(2)) u4 (.CLK(clk), .KEY(key), .start(start), .stop(stop), .loop(loop),
        .rom_addr(a4), .rom_data(r4), .sample_out(s4), .sample_valid(v4), .spike_in(spike),
        .busy(b4), .done(d4), .spike_count(c4));
    ecg_sample_sequencer #(.LAST_ADDR(7), .CNT_W(4)) u5 (.CLK(clk), .KEY(key), .start(start), .stop(stop), .loop(loop),
        .rom_addr(a5), .rom_data(r5), .sample_out(s5), .sample_valid(v5), .spike_in(spike),
        .busy(b5), .done(d5), .spike_count(c5));

    task automatic do_reset();
        start = 1'b0; stop = 1'b0; loop = 1'b0; spike = 1'b0;
        key = 1'b1;
        repeat (2) @(negedge clk);
        key = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        key = 1'b1;
        #1;
        checks++;
        if ({a1, s1, v1, b1, d1, c1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%0d sample=%0d valid=%b busy=%b done=%b count=%0d expected all 0", a1, s1, v1, b1, d1, c1);
        end
        do_reset();
        checks++;
        if ({b1, d1, v1} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b valid=%b expected 0", b1, d1, v1);
        end
    endtask

    task automatic test_playback();
        do_reset();
        start = 1'b1;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
            checks++;
            if (v1 !== (t >= 2 && t <= 9)) begin
                errors++;
                $display("FAIL play_valid t=%0d got %b expected %b", t, v1, (t >= 2 && t <= 9));
            end
            if (t >= 2 && t <= 9) begin
                checks++;
                if (s1 !== 20'(98 + t)) begin
                    errors++;
                    $display("FAIL play_data t=%0d got %0d expected %0d", t, s1, 98 + t);
                end
            end
            checks++;
            if (d1 !== (t == 10) || b1 !== (t <= 10)) begin
                errors++;
                $display("FAIL play_done_busy t=%0d got done=%b busy=%b expected done=%b busy=%b", t, d1, b1, (t == 10), (t <= 10));
            end
        end
    endtask

    task automatic test_decim();
        int dones = 0;
        do_reset();
        start = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
            if (d2) dones++;
            checks++;
            if (v2 !== (t >= 2 && t <= 14 && (t - 2) % 4 == 0)) begin
                errors++;
                $display("FAIL decim_valid t=%0d got %b", t, v2);
            end
            if (v2 && s2 !== 20'(100 + (t - 2) / 4)) begin
                checks++;
                errors++;
                $display("FAIL decim_data t=%0d got %0d expected %0d", t, s2, 100 + (t - 2) / 4);
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL decim_done got %0d pulses expected 1", dones);
        end
    endtask

    task automatic test_loop_stop();
        do_reset();
        loop = 1'b1;
        start = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
            if (t == 19) stop = 1'b1;
            if (t == 20) stop = 1'b0;
            if (t <= 19) begin
                checks++;
                if (a1 !== 12'(t % 8)) begin
                    errors++;
                    $display("FAIL loop_addr t=%0d got %0d expected %0d", t, a1, t % 8);
                end
            end
            checks++;
            if (v1 !== (t >= 2 && t <= 21) || (v1 && s1 !== 20'(100 + (t - 2) % 8))) begin
                errors++;
                $display("FAIL loop_sample t=%0d got valid=%b data=%0d expected valid=%b data=%0d", t, v1, s1, (t >= 2 && t <= 21), 100 + (t - 2) % 8);
            end
            checks++;
            if (d1 !== (t == 22)) begin
                errors++;
                $display("FAIL loop_done t=%0d got %b expected %b", t, d1, (t == 22));
            end
        end
        loop = 1'b0;
    endtask

    task automatic test_rdlat2_stop();
        do_reset();
        start = 1'b1;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
            if (t == 2) stop = 1'b1;
            if (t == 3) stop = 1'b0;
            checks++;
            if (v4 !== (t >= 3 && t <= 5) || (v4 && s4 !== 20'(97 + t))) begin
                errors++;
                $display("FAIL lat2_sample t=%0d got valid=%b data=%0d expected valid=%b data=%0d", t, v4, s4, (t >= 3 && t <= 5), 97 + t);
            end
            checks++;
            if (d4 !== (t == 6)) begin
                errors++;
                $display("FAIL lat2_done t=%0d got %b expected %b", t, d4, (t == 6));
            end
        end
    endtask

    task automatic test_spikes();
        do_reset();
        loop = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            spike = 1'b1;
            repeat (3) @(negedge clk);
            spike = 1'b0;
            repeat (2) @(negedge clk);
        end
        checks++;
        if (c1 !== 16'd3) begin
            errors++;
            $display("FAIL spike_count3 got %0d expected 3", c1);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 40 && !d1; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (b1 !== 1'b0) begin
            errors++;
            $display("FAIL spike_stop_idle got busy=%b expected 0", b1);
        end
        for (int p = 0; p < 2; p++) begin
            spike = 1'b1;
            @(negedge clk);
            spike = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (c1 !== 16'd3) begin
            errors++;
            $display("FAIL spike_idle_hold got %0d expected 3", c1);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < 21; p++) begin
            spike = 1'b1;
            @(negedge clk);
            spike = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (c5 !== 4'd15) begin
            errors++;
            $display("FAIL spike_saturate got %0d expected 15", c5);
        end
        checks++;
        if (c1 !== 16'd21) begin
            errors++;
            $display("FAIL spike_count21 got %0d expected 21", c1);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop = 1'b0;
    endtask

    task automatic test_control_edges();
        int dones = 0;
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        spike = 1'b1;
        @(negedge clk);
        spike = 1'b0;
        repeat (2) @(negedge clk);
        key = 1'b1;
        #1;
        checks++;
        if ({a1, s1, v1, b1, d1, c1} !== '0) begin
            errors++;
            $display("FAIL midrun_reset got addr=%0d sample=%0d valid=%b busy=%b done=%b count=%0d expected all 0", a1, s1, v1, b1, d1, c1);
        end
        @(negedge clk);
        key = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (d1 || b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midrun_no_done got %0d active cycles expected 0", dones);
        end
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b1 !== 1'b0) begin
                errors++;
                $display("FAIL start_stop_same got busy=%b expected 0", b1);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_playback();
        test_decim();
        test_loop_stop();
        test_rdlat2_stop();
        test_spikes();
        test_control_edges();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ecg_sample_sequencer.md
Name: ecg_sample_sequencer

Overview:
- Controller for ECG sample playback from the 4096 x 20-bit sample ROM into the IN_V2_Char neuron.
- Generates ROM addresses under start/stop control and compensates for the ROM read latency.
- Delivers each sample to the neuron with a one-cycle valid strobe and counts the spikes the neuron emits during a run.
- Replaces free-running address counters in benches and top level.

Parameters:
- ADDR_W, 12, ROM address width.
- DATA_W, 20, sample width.
- LAST_ADDR, 4095, final address of a pass.
- RD_LAT, 1, ROM read latency in cycles; legal values are 1 or 2.
- DECIM, 1, cycles between address issues; legal range 1..255.
- CNT_W, 16, spike counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- KEY  in  1  reset, asynchronous, active-high.
- start  in  1  begin a run; pulse.
- stop  in  1  abort a run; pulse.
- loop  in  1  at LAST_ADDR, wrap to 0 instead of finishing; sampled at each wrap decision.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  DATA_W  ROM read data.
- sample_out  out  DATA_W  registered sample to the neuron.
- sample_valid  out  1  sample_out is new this cycle.
- spike_in  in  1  neuron spike output.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at end of run.
- spike_count  out  CNT_W  spikes counted in the current or last run.

Behaviour:
- Reset values: rom_addr=0, sample_out=0, sample_valid=0, busy=0, done=0, spike_count=0, state=IDLE, read pipeline cleared, decimation counter=0.
- Reset asserted mid-run aborts immediately.
- After reset, the first rising spike_in edge is not counted unless spike_in was low for at least one sampled cycle.

States:
- IDLE:
  - start=1 and stop=0 -> RUN.
  - Same edge: rom_addr=0, issue slot 0, spike_count cleared, decimation counter cleared.
  - start and stop together -> stay IDLE.
- RUN:
  - An issue occurs when the decimation counter reaches DECIM-1; the counter then resets.
  - On an issue, rom_addr advances by 1, or follows the LAST_ADDR rule below.
  - At LAST_ADDR with loop=1, the next issue is address 0.
  - At LAST_ADDR with loop=0, no further issue -> DRAIN.
  - stop=1 -> DRAIN; no new issue that cycle.
  - start is ignored.
- DRAIN:
  - No issues.
  - Waits until the read pipeline is empty, including the final sample_valid -> DONE.
- DONE:
  - done=1 for exactly one cycle -> IDLE.
  - spike_count holds its value until the next start.

Read pipeline:
- Each issue pushes a 1 into an RD_LAT-deep shift register.
- When the tap is 1, sample_out <= rom_data and sample_valid=1 on the following cycle.
- Issue-to-sample_valid latency is RD_LAT+1 cycles, fixed.
- Samples are emitted in address order, with no loss or duplication.
- In-flight reads at stop or at LAST_ADDR are always delivered.

Spike counting:
- Counts rising edges of spike_in, using a registered previous value.
- Counts only while busy=1.
- Saturates at 2^CNT_W-1; no wrap.

Address arithmetic:
- ADDR_W-bit unsigned; LAST_ADDR must be ≤ 2^ADDR_W-1.
- With LAST_ADDR=2^ADDR_W-1, the natural wrap and the explicit wrap coincide.

Optional Feature:
- Macro: ECG_SEQ_SPIKE_ADDR_EN.
- Defined:
  - Adds output last_spike_addr [ADDR_W-1:0], reset value 0.
  - On each counted spike edge, it captures the address of the most recently delivered sample.
  - If no sample has been delivered yet in the run, it captures 0.
  - Cleared on start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. RD_LAT=1, DECIM=1, LAST_ADDR=7, loop=0, ROM word[n]=n+100, start pulse:
   - sample_valid is high for 8 consecutive cycles, first at 2 cycles after start, carrying 100..107.
   - done pulses once, 1 cycle after the last valid.
   - busy falls with the done cycle.
2. DECIM=4, LAST_ADDR=3:
   - sample_valid pulses spaced exactly 4 cycles apart, 4 pulses total, values 100..103.
3. loop=1, LAST_ADDR=7, run 20 issues, then stop:
   - addresses run 0..7,0..7,0..3 and all 20 samples are delivered in order.
   - No sample is delivered after the 20th; done pulses once.
4. RD_LAT=2, stop asserted the cycle after the third issue:
   - exactly 3 samples (100,101,102) are delivered, the last at 3 cycles after its issue.
   - done follows.
5. Spike counting:
   - Drive spike_in high for 3 cycles, three times, while busy: spike_count=3.
   - Drive spike_in while idle: spike_count is unchanged.
   - Force 2^CNT_W+5 edges with CNT_W=4: spike_count=15.
6. Reset and control edge cases:
   - Assert KEY mid-RUN: all outputs are 0 immediately, with no done pulse.
   - start and stop in the same cycle in IDLE: busy stays 0.
